bram_write_loader: RTL and testbench
====================================

# bram_write_loader

Byte-stream loader that fills the write port of a 256x16 iCE40 block RAM (SB_RAM256x16-class primitive) with 16-bit words. It is the write side of the instruction-memory path. A host-facing byte source (UART receiver, SPI slave, test harness) feeds it bytes over a valid/ready handshake. It assembles the bytes low-byte-first into halfwords and issues one write per halfword at sequential addresses starting at 0. The read-only instruction RAM wrapper then serves those words to the core, which is held in stall via `busy`.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM word-address width.
- `DEPTH`, default 256: number of RAM words. Must equal 2**ADDR_W.

Ports:
- `clk`, in, 1: single clock. Also drives the RAM `WCLK` externally.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a load session. Honoured only in IDLE or DONE.
- `abort`, in, 1: return to IDLE from any state.
- `word_count`, in, ADDR_W+1: number of words to load, 0..DEPTH. Latched when `start` is accepted.
- `in_valid`, in, 1: byte source has data.
- `in_byte`, in, 8: byte data.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `WE`, out, 1: RAM write enable. Registered; one-cycle pulse per word.
- `WADDR`, out, ADDR_W: RAM write address. Registered.
- `WDATA`, out, 16: RAM write data. Registered as {high byte, low byte}.
- `MASK`, out, 16: constant 16'h0000, so all bits are written.
- `busy`, out, 1: session in progress (states LO, HI, WRITE).
- `done`, out, 1: high while in DONE.
- `words_written`, out, ADDR_W+1: words written in the current or last session.

## Operation
FSM states: IDLE, LO, HI, WRITE, DONE. All state is registered.
- IDLE:
  - `in_ready`=0.
  - `start` with `word_count`≠0: latch the count, clear `words_written`, set addr=0, go to LO.
  - `start` with `word_count`=0: go directly to DONE.
- LO:
  - `in_ready`=1.
  - On handshake (`in_valid`&&`in_ready`): capture the low byte, go to HI.
- HI:
  - `in_ready`=1.
  - On handshake: on the same edge, load `WADDR`=addr, `WDATA`={in_byte, lo}, `WE`=1; go to WRITE.
- WRITE:
  - `in_ready`=0. `WE` is high for exactly this cycle.
  - On exit: `WE`←0, addr←addr+1, `words_written`←`words_written`+1.
  - If the new `words_written` equals the latched count, go to DONE; otherwise go to LO.
- DONE:
  - `done`=1, `in_ready`=0.
  - `start` begins a new session with the same rules as IDLE.
- `abort`:
  - Forces IDLE on the next edge from any state.
  - Discards any captured low byte.
  - `words_written` holds its value.
  - In WRITE, the write already presented on the port completes, and `words_written` still counts it.
  - `abort` takes priority over a simultaneous `start` or handshake, so that byte is not consumed and `in_ready` is not honoured.
- `start` in LO, HI or WRITE is ignored.
- Address range:
  - addr never exceeds DEPTH-1 because the session ends when the count is reached.
  - With `word_count`=DEPTH, the last write is at DEPTH-1 and the internal addr wraps to 0 unused.
  - `word_count`>DEPTH is out of range; the loader clamps it to DEPTH when latching.
- Bytes arriving while `in_ready`=0 are not consumed. The source must hold them.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `WE`=0, `WADDR`=0, `WDATA`=0, `busy`=0, `done`=0, `words_written`=0. `MASK`=0 always.
- Reset asserted mid-session: immediate return to IDLE. `WE` drops asynchronously and no partial write occurs.
- `start` accepted at edge N: `in_ready`=1 during cycle N+1.
- With a continuous source, each word takes 3 cycles: LO, HI, WRITE. A load of k words takes 3k cycles from the first `in_ready` to DONE.
- Gaps in `in_valid` stall in LO or HI without limit. No timeout.
- `words_written` updates on the edge leaving WRITE.
- `done` rises on the same edge that `words_written` reaches the count.

## Test plan
- Load 3 words:
  - Stimulus: `word_count`=3; bytes 11,22,33,44,55,66 streamed back-to-back.
  - Response: WE pulses with (WADDR,WDATA) = (0,2211), (1,4433), (2,6655).
  - Response: `done`=1, `words_written`=3, 9 cycles from first `in_ready`.
- Full depth:
  - Stimulus: `word_count`=256; byte pattern i, ~i.
  - Response: 256 writes, last at WADDR=FF.
  - Response: no write to address 0 after it, `done`=1, `words_written`=256.
  - Response: the read port returns the same data.
- Zero count:
  - Stimulus: `start` with `word_count`=0.
  - Response: `done`=1 the next cycle; `WE` never asserted; `in_ready` stays 0.
- Backpressure:
  - Stimulus: `in_valid` toggled randomly; `start` pulsed while busy.
  - Response: identical writes, no duplicated or dropped bytes.
  - Response: the mid-session `start` has no effect.
- Abort:
  - Stimulus: `abort` in HI after low byte AA.
  - Response: IDLE next cycle with no WE.
  - Response: a following `start` restarts at WADDR=0 and does not reuse AA.
  - Stimulus: `abort` in WRITE.
  - Response: that write still occurs.
- Reset:
  - Stimulus: `reset` asserted during WRITE.
  - Response: all outputs reach their reset values without waiting for a clock edge.
  - Response: normal loading resumes after deassert and `start`.

Source files
------------

// File: rtl/bram_write_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_write_loader_if
// Description : Bundles the byte-stream handshake and the block-RAM write port
//               of the instruction-memory loader.
//               in_valid/in_byte/in_ready : byte source handshake
//               WE/WADDR/WDATA/MASK       : RAM write port
//               master : byte source / RAM side
//               slave  : loader side
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_write_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [15:0]       WDATA;
  logic [15:0]       MASK;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  WE,
    input  WADDR,
    input  WDATA,
    input  MASK
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output WE,
    output WADDR,
    output WDATA,
    output MASK
  );
endinterface
`default_nettype wire

// File: rtl/bram_write_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram_write_loader
// Description : Assembles a low-byte-first byte stream into 16-bit words and
//               writes them to sequential block-RAM addresses from 0.
//   clk, reset      : clock, asynchronous active-high reset
//   start, abort    : begin a session (IDLE/DONE only) / return to IDLE
//   word_count      : words to load, latched on start, clamped to DEPTH
//   bus (slave)     : byte handshake in, RAM write port out
//   busy, done      : session in progress / session complete
//   words_written   : words written in the current or last session
// Revision    : 1.0 - initial release
// ============================================================================
module bram_write_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256     // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  bram_write_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_one      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = (ADDR_W)'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [7:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_wdata;

  logic              w_ready;
  logic              w_accept_start;
  logic              w_capture_lo;
  logic              w_issue;
  logic              w_retire;
  logic [ADDR_W:0]   w_count_clamped;
  logic [ADDR_W:0]   w_words_inc;

  assign w_count_clamped = (word_count > c_depth) ? c_depth : word_count;
  assign w_words_inc     = r_words + c_one;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle strobes. Abort outranks start and the byte
  // handshake, so in_ready is withheld while abort is high.
  always_comb begin
    w_next         = r_state;
    w_ready        = 1'b0;
    w_accept_start = 1'b0;
    w_capture_lo   = 1'b0;
    w_issue        = 1'b0;
    w_retire       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (start) begin
          w_accept_start = 1'b1;
          w_next = (w_count_clamped == '0) ? ST_DONE : ST_LO;
        end
      end
      ST_LO: begin
        w_ready = ~abort;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (bus.in_valid) begin
          w_capture_lo = 1'b1;
          w_next       = ST_HI;
        end
      end
      ST_HI: begin
        w_ready = ~abort;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (bus.in_valid) begin
          w_issue = 1'b1;
          w_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The write on the port completes even under abort, so it is counted.
        w_retire = 1'b1;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_words_inc == r_count) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_LO;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered RAM write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo    <= 8'h00;
      r_addr  <= '0;
      r_count <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 16'h0000;
    end else begin
      r_we <= 1'b0;
      if (abort) begin
        r_lo <= 8'h00;
      end
      if (w_accept_start) begin
        r_count <= w_count_clamped;
        r_words <= '0;
        r_addr  <= '0;
      end
      if (w_capture_lo) begin
        r_lo <= bus.in_byte;
      end
      if (w_issue) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= {bus.in_byte, r_lo};
      end
      if (w_retire) begin
        // With a full-depth load the address wraps to 0 here but is never used.
        r_addr  <= r_addr + c_addr_one;
        r_words <= w_words_inc;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.WE         = r_we;
  assign bus.WADDR      = r_waddr;
  assign bus.WDATA      = r_wdata;
  assign bus.MASK       = 16'h0000;
  assign busy           = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_WRITE);
  assign done           = (r_state == ST_DONE);
  assign words_written  = r_words;

endmodule
`default_nettype wire

// File: tb/tb_bram_write_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_write_loader
// Description : Self-checking bench for bram_write_loader. Session vectors come
//               from a table; expected RAM writes are queued as bytes are
//               generated and popped when WE is observed. Abort and reset
//               corner cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_write_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [ADDR_W:0] word_count = '0;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] words_written;

  bram_write_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bram_write_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .word_count    (word_count),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] exp_mem [DEPTH];
  logic [15:0] mem     [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model standing in for the block RAM; its contents act as the read port.
  always @(posedge clk) if (bus.WE) mem[bus.WADDR] <= bus.WDATA;

  // Write monitor: every WE pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (bus.WE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", bus.WADDR, bus.WDATA);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.WADDR !== e.addr || bus.WDATA !== e.data) begin
          errors++;
          $display("FAIL write actual=(%0h,%0h) required=(%0h,%0h)",
                   bus.WADDR, bus.WDATA, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; in backpressure mode insert random idle cycles, some of
  // which carry a start pulse that must be ignored mid-session.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int gaps;
    int guard;
    gaps = bp ? int'($urandom_range(0, 3)) : 0;
    repeat (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        start      = 1'b1;
        word_count = 9'd1;
      end
      step();
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    guard = 0;
    while (!bus.in_ready) begin
      step();
      guard++;
      if (guard > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic readback(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("readback_mismatches", 32'(bad), 32'd0);
  endtask

  task automatic run_session(input logic [ADDR_W:0] wc, input int pat, input bit bp,
                             input int exp_n, input int exp_cyc);
    logic [7:0] lo;
    logic [7:0] hi;
    int c0;
    int guard;
    word_count = wc;
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    if (exp_n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
    end else begin
      chk("first_in_ready", 32'(bus.in_ready), 32'd1);
    end
    for (int w = 0; w < exp_n; w++) begin
      case (pat)
        0: begin lo = 8'((2*w+1)*17); hi = 8'((2*w+2)*17); end
        1: begin lo = 8'(w); hi = ~8'(w); end
        default: begin lo = 8'($urandom); hi = 8'($urandom); end
      endcase
      exp_q.push_back('{addr: 8'(w), data: {hi, lo}});
      exp_mem[w] = {hi, lo};
      send_byte(lo, bp);
      send_byte(hi, bp);
    end
    guard = 0;
    while (!done && guard < 20) begin
      step();
      guard++;
    end
    chk("done", 32'(done), 32'd1);
    chk("words_written", 32'(words_written), 32'(exp_n));
    chk("busy_after", 32'(busy), 32'd0);
    chk("in_ready_after", 32'(bus.in_ready), 32'd0);
    if (exp_cyc >= 0) chk("session_cycles", 32'(cyc - c0), 32'(exp_cyc));
    repeat (3) step();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    readback(exp_n);
  endtask

  typedef struct {
    logic [ADDR_W:0] wc;
    int              pat;
    bit              bp;
    int              exp_n;
    int              exp_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo;
    logic [7:0] hi;

    vecs[0] = '{wc: 9'd3,   pat: 0, bp: 1'b0, exp_n: 3,   exp_cyc: 9};
    vecs[1] = '{wc: 9'd0,   pat: 0, bp: 1'b0, exp_n: 0,   exp_cyc: -1};
    vecs[2] = '{wc: 9'd1,   pat: 1, bp: 1'b0, exp_n: 1,   exp_cyc: 3};
    vecs[3] = '{wc: 9'd256, pat: 1, bp: 1'b0, exp_n: 256, exp_cyc: 768};
    vecs[4] = '{wc: 9'd7,   pat: 2, bp: 1'b1, exp_n: 7,   exp_cyc: -1};
    vecs[5] = '{wc: 9'd300, pat: 2, bp: 1'b0, exp_n: 256, exp_cyc: 768};

    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.WE), 32'd0);
    chk("rst_waddr", 32'(bus.WADDR), 32'd0);
    chk("rst_wdata", 32'(bus.WDATA), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("mask", 32'(bus.MASK), 32'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      run_session(vecs[v].wc, vecs[v].pat, vecs[v].bp, vecs[v].exp_n, vecs[v].exp_cyc);
    end

    // Abort in HI after low byte AA: no write, and AA is not reused.
    word_count = 9'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'hAA, 1'b0);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hBB;
    #1;
    chk("abort_hi_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_hi_busy", 32'(busy), 32'd0);
    chk("abort_hi_done", 32'(done), 32'd0);
    chk("abort_hi_we", 32'(bus.WE), 32'd0);
    chk("abort_hi_words", 32'(words_written), 32'd0);
    step();
    run_session(9'd1, 0, 1'b0, 1, 3);

    // Abort in WRITE: the presented write still lands and is counted.
    word_count = 9'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    lo = 8'h5A;
    hi = 8'hC3;
    exp_q.push_back('{addr: 8'h00, data: {hi, lo}});
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    chk("abort_wr_we", 32'(bus.WE), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_wr_busy", 32'(busy), 32'd0);
    chk("abort_wr_done", 32'(done), 32'd0);
    chk("abort_wr_words", 32'(words_written), 32'd1);
    chk("abort_wr_mem", 32'(mem[0]), 32'h0000C35A);
    chk("abort_wr_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset during WRITE: outputs clear without a clock edge, no write lands.
    word_count = 9'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("pre_reset_we", 32'(bus.WE), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(bus.WE), 32'd0);
    chk("async_rst_waddr", 32'(bus.WADDR), 32'd0);
    chk("async_rst_wdata", 32'(bus.WDATA), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_words", 32'(words_written), 32'd0);
    step();
    reset = 1'b0;
    step();
    run_session(9'd2, 1, 1'b0, 2, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
